// File: rtl/prng_pkg.sv
// Shared types, widths and LFSR helpers for the PRNG scheduler.
package prng_pkg;

   localparam int unsigned D_W    = 16;
   localparam int unsigned C_W    = 8;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned SEED_W = 24;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned TICK_W = 24;

   // Feedback taps: data bits 15,14,12,3; control bits 7,5,4,3
   localparam logic [D_W-1:0] D_TAPS = 16'hD008;
   localparam logic [C_W-1:0] C_TAPS = 8'hB8;

   localparam logic [TICK_W-1:0] TICK_DIV_DEFAULT = 24'd10_000_000;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_STEP    = 2'd1;
   localparam state_t ST_DELIVER = 2'd2;

   function automatic logic [D_W-1:0] d_step(input logic [D_W-1:0] d);
      return {d[D_W-2:0], ~(^(d & D_TAPS))};
   endfunction

   function automatic logic [C_W-1:0] c_step(input logic [C_W-1:0] c);
      return {c[C_W-2:0], ~(^(c & C_TAPS))};
   endfunction

   // All-ones is the XNOR lock-up state; substitute zero
   function automatic logic [D_W-1:0] d_unlock(input logic [D_W-1:0] s);
      return (&s) ? '0 : s;
   endfunction

   function automatic logic [C_W-1:0] c_unlock(input logic [C_W-1:0] s);
      return (&s) ? '0 : s;
   endfunction

endpackage

// File: rtl/prng_byte_mux.sv
// Folds the 16-bit data LFSR into a byte, each bit chosen by a control LFSR bit.
module prng_byte_mux
   import prng_pkg::*;
(
   input  logic [D_W-1:0]    d,
   input  logic [C_W-1:0]    c,
   output logic [BYTE_W-1:0] mux_byte_c
);

   for (genvar j = 0; j < BYTE_W; j++) begin : g_sel
      assign mux_byte_c[j] = c[j] ? d[2*j+1] : d[2*j];
   end

endmodule

// File: rtl/prng_sched.sv
// Round-robin random-byte server with display tick; reseeding is enabled by
// defining PRNG_SCHED_RESEED_EN.
module prng_sched
   import prng_pkg::*;
#(
   parameter int unsigned        NREQ     = 4,
   parameter logic [TICK_W-1:0]  TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   output logic [NREQ-1:0]   gnt,
   output logic              rnd_valid,
   output logic [BYTE_W-1:0] rnd_data,
   input  logic              seed_load,
   input  logic [SEED_W-1:0] seed,
   output logic              tick,
   output logic [BYTE_W-1:0] disp_byte
);

   localparam logic [NREQ-1:0]  GNT_ONE  = NREQ'(1);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

   state_t              state, state_nxt;
   logic [D_W-1:0]      d_q;
   logic [C_W-1:0]      c_q;
   logic [IDX_W-1:0]    winner, last_grant, pick, cand;
   logic [3:0]          sum;
   logic [7:0]          req8;
   logic [BYTE_W-1:0]   mux_byte;
   logic [TICK_W-1:0]   tick_cnt, tick_cnt_nxt;
   logic                tick_now, tick_adv;
   logic                step_req, latch_win, deliver, seed_ld;

`ifdef PRNG_SCHED_RESEED_EN
   assign seed_ld = seed_load;
`else
   logic unused_seed_load;
   assign unused_seed_load = seed_load;
   assign seed_ld          = 1'b0;
`endif

   prng_byte_mux u_mux (
      .d          (d_q),
      .c          (c_q),
      .mux_byte_c (mux_byte)
   );

   assign req8 = 8'(req);

   // Round-robin search from last_grant+1; the nearest requester is assigned last
   always_comb begin
      pick = last_grant;
      sum  = '0;
      cand = '0;
      for (int unsigned k = NREQ; k >= 1; k--) begin
         sum = 4'(last_grant) + 4'(k);
         if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
         cand = sum[IDX_W-1:0];
         if (req8[cand]) pick = cand;
      end
   end

   assign tick_now     = (tick_cnt == TICK_DIV - TICK_W'(1));
   assign tick_cnt_nxt = tick_now ? '0 : tick_cnt + TICK_W'(1);
   // A tick only steps the LFSRs when no requester could be using them
   assign tick_adv     = tick_now && (state == ST_IDLE) && (req == '0);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      step_req  = 1'b0;
      latch_win = 1'b0;
      deliver   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|req) begin
               latch_win = 1'b1;
               state_nxt = ST_STEP;
            end
         end
         ST_STEP: begin
            step_req  = 1'b1;
            state_nxt = req8[winner] ? ST_DELIVER : ST_IDLE;
         end
         ST_DELIVER: begin
            deliver   = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (seed_ld) begin
         state_nxt = ST_IDLE;
         step_req  = 1'b0;
         latch_win = 1'b0;
         deliver   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         d_q        <= '0;
         c_q        <= '0;
         winner     <= '0;
         last_grant <= LAST_RST;
         gnt        <= '0;
         rnd_valid  <= 1'b0;
         rnd_data   <= '0;
         disp_byte  <= '0;
         tick       <= 1'b0;
         tick_cnt   <= '0;
      end else begin
         tick_cnt <= tick_cnt_nxt;
         tick     <= (tick_cnt_nxt == TICK_DIV - TICK_W'(1));
         if (tick_now) disp_byte <= mux_byte;

         if (seed_ld) begin
            d_q <= d_unlock(seed[D_W-1:0]);
            c_q <= c_unlock(seed[SEED_W-1:D_W]);
         end else if (step_req || tick_adv) begin
            d_q <= d_step(d_q);
            c_q <= c_step(c_q);
         end

         if (latch_win) winner <= pick;

         rnd_valid <= deliver;
         gnt       <= deliver ? (GNT_ONE << winner) : '0;
         if (deliver) begin
            rnd_data   <= mux_byte;
            last_grant <= winner;
         end
      end
   end

endmodule

// File: doc/prng_sched.md
PRNG_SCHED -- requirements
Module: prng_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter TICK_DIV, default 24'd10_000_000, meaning the display-refresh tick period in clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req, input, NREQ bits: per-requester level request for one random byte.
REQ-006 SHALL have port gnt, output, NREQ bits: one-hot grant, asserted only together with rnd_valid.
REQ-007 SHALL have port rnd_valid, output, 1 bit: one-cycle pulse qualifying rnd_data.
REQ-008 SHALL have port rnd_data, output, 8 bits: delivered random byte.
REQ-009 SHALL have port seed_load, input, 1 bit: load request for the LFSR seeds.
REQ-010 SHALL have port seed, input, 24 bits: seed value; [15:0] is the data LFSR, [23:16] the control LFSR.
REQ-011 SHALL have port tick, output, 1 bit: one-cycle pulse every TICK_DIV cycles.
REQ-012 SHALL have port disp_byte, output, 8 bits: byte for the 7-segment decoders, updated on tick.

Function
REQ-013 SHALL hold a 16-bit data LFSR stepped as d <= {d[14:0], ~(d[15]^d[14]^d[12]^d[3])}.
REQ-014 SHALL hold an 8-bit control LFSR stepped as c <= {c[6:0], ~(c[7]^c[5]^c[4]^c[3])}, always on the same cycle as the data LFSR.
REQ-015 SHALL form mux_byte[j] = c[j] ? d[2j+1] : d[2j] for j = 0..7, combinationally from the current LFSR state.
REQ-016 SHALL implement FSM states IDLE, STEP and DELIVER.
REQ-017 In IDLE with any req bit set, SHALL latch the round-robin winner and go to STEP.
- Search starts at last_grant+1 and wraps modulo NREQ.
- last_grant resets to NREQ-1, so requester 0 wins first.
REQ-018 In STEP, SHALL advance both LFSRs once.
- Goes to DELIVER if req of the latched winner is still high.
- Otherwise returns to IDLE, with no delivery and last_grant unchanged.
REQ-019 In DELIVER, SHALL drive rnd_valid=1, gnt=onehot(winner) and rnd_data=mux_byte for exactly one cycle.
- Updates last_grant to the winner.
- Returns to IDLE.
REQ-020 Latency: req seen in IDLE at cycle N SHALL give rnd_valid at cycle N+2; sustained throughput is one byte per 3 cycles.
REQ-021 A tick counter SHALL count 0..TICK_DIV-1 and wrap; tick SHALL pulse on the cycle the count equals TICK_DIV-1.
REQ-022 On tick, disp_byte SHALL load mux_byte.
- If the FSM is in IDLE with req==0, both LFSRs also advance that cycle.
- Otherwise the tick advance is dropped, because a requester step has priority.
REQ-023 seed_load SHALL override everything else.
- Loads d <= seed[15:0] and c <= seed[23:16].
- Forces the FSM to IDLE with no delivery.
- Does not disturb the tick counter or last_grant.
REQ-024 The all-ones XNOR lock-up state SHALL be rejected: a seed field equal to all-ones loads 0 instead.
REQ-025 Outside DELIVER, gnt SHALL be 0, rnd_valid 0, and rnd_data SHALL hold its last value.

Reset
REQ-026 reset SHALL set the following: d=0, c=0, FSM=IDLE, tick counter=0, last_grant=NREQ-1, gnt=0, rnd_valid=0, rnd_data=0, disp_byte=0, tick=0.
REQ-027 reset SHALL take priority over seed_load.
REQ-028 Reset asserted in STEP or DELIVER SHALL abort the transaction with no rnd_valid pulse.

Configuration
REQ-029 Macro PRNG_SCHED_RESEED_EN SHALL select reseed support.
- Defined: seed_load and seed behave per REQ-023/024.
- Undefined: both ports exist but are ignored; the LFSRs start only from reset state 0.

Structure
REQ-030 Shared package prng_pkg SHALL hold the FSM state typedef, the LFSR widths (16, 8), the tap constants, and the TICK_DIV default.
REQ-031 Mux selection SHALL live in one combinational sub-module, prng_byte_mux; the LFSRs, arbiter, FSM and tick live in prng_sched.

Verification
REQ-032 Reset, then req=4'b0001 held: the first rnd_valid SHALL come 2 cycles after req is sampled, with d=0x0001, c=0x01, rnd_data=0x00; the second delivery SHALL give d=0x0003, c=0x03, rnd_data=0x01.
REQ-033 req=4'b1111 held: gnt SHALL sequence 0001, 0010, 0100, 1000, 0001, with one delivery every 3 cycles.
REQ-034 req[2] dropped during STEP: SHALL give no rnd_valid, the LFSR advanced by 1, and the next grant goes to requester 2 again if it re-requests first.
REQ-035 seed_load with seed=24'hFF_FFFF, then req: the delivery SHALL show d=0x0001 and c=0x01 (lock-up substitution followed by one step).
REQ-036 With TICK_DIV=4 and no requests: tick SHALL pulse every 4 cycles and disp_byte SHALL follow the LFSR sequence.
- A tick coinciding with a STEP cycle SHALL not double-advance the LFSRs.
REQ-037 Reset asserted on the DELIVER cycle: rnd_valid SHALL stay 0 and all outputs SHALL return to their reset values on the next edge.
